// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobe, row sync, debounce FSM and valid/ready event output.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_DLY dwells.
module keypad_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int REPEAT_DLY = 250,
    localparam int KW        = $clog2(ROWS*COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overrun
);
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] DB = 4'(DEBOUNCE);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t          state, state_nxt;
    logic [ROWS-1:0] row_s1, row_s2;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [CIW-1:0]  col_idx, col_idx_nxt, col_adv;
    logic [RIW-1:0]  cap_row, cap_row_nxt, low_idx;
    logic [3:0]      deb_cnt, deb_cnt_nxt;
    logic            any_low, emit;
    logic [KW-1:0]   emit_code;
`ifdef KEYPAD_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_DLY + 1);
    logic [RPW-1:0]  rpt_cnt, rpt_cnt_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
    assign tick = (tick_cnt == TW'(SCAN_DIV - 1));

    // Lowest-numbered active row wins when several are low together.
    always_comb begin
        low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            if (!row_s2[i]) low_idx = RIW'(i);
    end

    assign any_low   = ~&row_s2;
    assign col_adv   = (col_idx == CIW'(COLS - 1)) ? '0 : col_idx + CIW'(1);
    assign emit_code = KW'(cap_row_nxt) * KW'(COLS) + KW'(col_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_SCAN;
            col_idx <= '0;
            cap_row <= '0;
            deb_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            col_idx <= col_idx_nxt;
            cap_row <= cap_row_nxt;
            deb_cnt <= deb_cnt_nxt;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt <= rpt_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        col_idx_nxt = col_idx;
        cap_row_nxt = cap_row;
        deb_cnt_nxt = deb_cnt;
        emit        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_nxt = rpt_cnt;
`endif
        if (tick) begin
            case (state)
                S_SCAN: begin
                    if (any_low) begin
                        cap_row_nxt = low_idx;
                        if (DB == 4'd1) begin
                            emit        = 1'b1;
                            state_nxt   = S_HELD;
                            deb_cnt_nxt = '0;
                        end else begin
                            state_nxt   = S_DEBOUNCE;
                            deb_cnt_nxt = 4'd1;
                        end
                    end else begin
                        col_idx_nxt = col_adv;
                    end
                end
                S_DEBOUNCE: begin
                    if (!row_s2[cap_row]) begin
                        if (deb_cnt + 4'd1 == DB) begin
                            emit        = 1'b1;
                            state_nxt   = S_HELD;
                            deb_cnt_nxt = '0;
                        end else begin
                            deb_cnt_nxt = deb_cnt + 4'd1;
                        end
                    end else begin
                        deb_cnt_nxt = '0;
                        state_nxt   = S_SCAN;
                        col_idx_nxt = col_adv;
                    end
                end
                S_HELD: begin
                    if (row_s2[cap_row]) begin
                        if (DB == 4'd1) begin
                            state_nxt   = S_SCAN;
                            col_idx_nxt = col_adv;
                            deb_cnt_nxt = '0;
                        end else begin
                            state_nxt   = S_RELEASE;
                            deb_cnt_nxt = 4'd1;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rpt_cnt == RPW'(REPEAT_DLY - 1)) begin
                        emit        = 1'b1;
                        rpt_cnt_nxt = '0;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt + RPW'(1);
                    end
`endif
                end
                S_RELEASE: begin
                    if (row_s2[cap_row]) begin
                        if (deb_cnt + 4'd1 == DB) begin
                            state_nxt   = S_SCAN;
                            col_idx_nxt = col_adv;
                            deb_cnt_nxt = '0;
                        end else begin
                            deb_cnt_nxt = deb_cnt + 4'd1;
                        end
                    end else begin
                        state_nxt   = S_HELD;
                        deb_cnt_nxt = '0;
                    end
                end
                default: state_nxt = S_SCAN;
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        if (state_nxt != S_HELD) rpt_cnt_nxt = '0;
`endif
    end

    // Column drive follows the next index so col and col_idx stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) col <= '1;
        else     col <= ~(COLS'(1) << col_idx_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun  <= 1'b0;
            key_held <= (state_nxt == S_HELD) || (state_nxt == S_RELEASE);
            if (key_valid && key_ready) key_valid <= 1'b0;
            // A pending event is never overwritten; the new one is dropped instead.
            if (emit) begin
                if (key_valid) begin
                    overrun <= 1'b1;
                end else begin
                    key_valid <= 1'b1;
                    key_code  <= emit_code;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=2, 4x4, REPEAT_DLY=3) with a keypad matrix model.
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_ready, key_held, overrun;

    logic       pressed;
    int         pr, pc;
    int         nvec = 0, nerr = 0;
    int         acc = 0, ovr = 0, acc0;

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .REPEAT_DLY(3)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Switch matrix: a closed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'b1111;
        if (pressed && col[pc] == 1'b0) row[pr] = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid && key_ready) acc++;
            if (overrun) ovr++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] cur(input int sel);
        case (sel)
            0:       cur = {3'b000, key_valid};
            1:       cur = {3'b000, key_held};
            default: cur = col;
        endcase
    endfunction

    task automatic wait_until(input int sel, input logic [3:0] val, input string tag);
        int n = 0;
        while (cur(sel) !== val && n < 300) begin
            step(1);
            n++;
        end
        chk(tag, {28'd0, cur(sel)}, {28'd0, val});
    endtask

    initial begin
        rst = 1'b1; key_ready = 1'b1; pressed = 1'b0; pr = 0; pc = 0;
        step(3);
        chk("rst_col",     {28'd0, col}, 32'hF);
        chk("rst_code",    {28'd0, key_code}, 32'd0);
        chk("rst_valid",   {31'd0, key_valid}, 32'd0);
        chk("rst_held",    {31'd0, key_held}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

        // Idle scan: column 0 on first edge, then one column per 4 clocks
        @(negedge clk) rst = 1'b0;
        step(1);
        chk("scan_c0", {28'd0, col}, 32'b1110);
        step(4); chk("scan_c1",  {28'd0, col}, 32'b1101);
        step(4); chk("scan_c2",  {28'd0, col}, 32'b1011);
        step(4); chk("scan_c3",  {28'd0, col}, 32'b0111);
        step(4); chk("scan_wrap", {28'd0, col}, 32'b1110);
        chk("idle_no_evt", acc, 0);

        // Row 2 / column 1 -> code 9, one-cycle valid with ready high
        pr = 2; pc = 1; pressed = 1'b1;
        wait_until(0, 4'd1, "k9_valid");
        chk("k9_code", {28'd0, key_code}, 32'd9);
        chk("k9_held", {31'd0, key_held}, 32'd1);
        step(1);
        chk("k9_valid_drop", {31'd0, key_valid}, 32'd0);
        step(5);
        chk("k9_col_frozen", {28'd0, col}, 32'b1101);
        chk("k9_one_evt", acc, 1);
        pressed = 1'b0;
        step(4);
        chk("k9_held_rel", {31'd0, key_held}, 32'd1);
        wait_until(1, 4'd0, "k9_released");

        // Bounce: one tick low then high -> no event, next column
        wait_until(2, 4'b1011, "bounce_align");
        pr = 0; pc = 2; pressed = 1'b1;
        step(4);
        pressed = 1'b0;
        step(4);
        chk("bounce_col", {28'd0, col}, 32'b0111);
        chk("bounce_no_evt", acc, 1);
        chk("bounce_held", {31'd0, key_held}, 32'd0);

        // Ready low: code 5 pends, code 12 is dropped with one overrun pulse
        key_ready = 1'b0;
        pr = 1; pc = 1; pressed = 1'b1;
        wait_until(0, 4'd1, "k5_valid");
        chk("k5_code", {28'd0, key_code}, 32'd5);
        pressed = 1'b0;
        wait_until(1, 4'd0, "k5_released");
        pr = 3; pc = 0; pressed = 1'b1;
        wait_until(1, 4'd1, "k12_held");
        chk("ovr_pulse", {31'd0, overrun}, 32'd1);
        chk("ovr_code", {28'd0, key_code}, 32'd5);
        step(1);
        chk("ovr_one_cycle", {31'd0, overrun}, 32'd0);
        pressed = 1'b0;
        wait_until(1, 4'd0, "k12_released");
        chk("pend_valid", {31'd0, key_valid}, 32'd1);
        chk("pend_code", {28'd0, key_code}, 32'd5);
        chk("ovr_count", ovr, 1);
        key_ready = 1'b1;
        step(1);
        chk("pend_taken", {31'd0, key_valid}, 32'd0);
        chk("acc_after_pend", acc, 2);

        // Long hold of code 15: repeats only with the repeat option built in
        acc0 = acc;
        pr = 3; pc = 3; pressed = 1'b1;
        wait_until(0, 4'd1, "k15_valid");
        chk("k15_code", {28'd0, key_code}, 32'd15);
        step(47);
        chk("k15_held", {31'd0, key_held}, 32'd1);
`ifdef KEYPAD_REPEAT_EN
        chk("k15_repeats", acc - acc0, 4);
`else
        chk("k15_single", acc - acc0, 1);
`endif
        pressed = 1'b0;
        wait_until(1, 4'd0, "k15_released");

        // Reset while an event is pending and the key is still down
        key_ready = 1'b0;
        pr = 1; pc = 2; pressed = 1'b1;
        wait_until(0, 4'd1, "k6_valid");
        rst = 1'b1;
        #1;
        chk("mid_rst_col",   {28'd0, col}, 32'hF);
        chk("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        chk("mid_rst_held",  {31'd0, key_held}, 32'd0);
        chk("mid_rst_code",  {28'd0, key_code}, 32'd0);
        step(2);
        @(negedge clk) rst = 1'b0;
        step(1);
        chk("post_rst_c0", {28'd0, col}, 32'b1110);
        wait_until(0, 4'd1, "k6_revalid");
        chk("k6_code", {28'd0, key_code}, 32'd6);
        chk("k6_col", {28'd0, col}, 32'b1011);
        pressed = 1'b0;
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of row inputs (2..8).
REQ-002 SHALL have parameter COLS, default 4, number of column outputs (2..8).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clk cycles per column dwell (min 4).
REQ-004 SHALL have parameter DEBOUNCE, default 4, consecutive stable dwells for press/release (1..15).
REQ-005 SHALL have parameter REPEAT_DLY, default 250, dwells between auto-repeat events (used only with KEYPAD_REPEAT_EN).
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port row, input, ROWS, asynchronous active-low row sense with pull-ups; 1 = idle.
REQ-009 SHALL have port col, output, COLS, registered active-low column drive; exactly one bit low while scanning.
REQ-010 SHALL have port key_code, output, KW = $clog2(ROWS*COLS), code = row_index*COLS + col_index.
REQ-011 SHALL have ports key_valid (output, 1) and key_ready (input, 1), valid/ready event handshake.
REQ-012 SHALL have port key_held, output, 1, high while a debounced key is held.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when an event is dropped.

Function
REQ-014 SHALL pass row through a 2-flop synchronizer before use.
REQ-015 SHALL generate a tick every SCAN_DIV cycles (counter 0..SCAN_DIV-1, wrap); all FSM decisions occur on ticks only, sampling the synchronized row.
REQ-016 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-017 SCAN: if any synced row bit low on tick, capture col_index and lowest low row index, keep column, go DEBOUNCE with count=1; else advance col_index (COLS-1 wraps to 0).
REQ-018 DEBOUNCE: on tick, same captured row bit low -> count+1; reaching DEBOUNCE -> emit event, go HELD; captured bit high -> clear count, go SCAN and advance column.
REQ-019 HELD: key_held=1; on tick with captured row bit high go RELEASE with count=1.
REQ-020 RELEASE: on tick, bit high -> count+1, reaching DEBOUNCE -> go SCAN, advance column, key_held=0; bit low -> return HELD, no new event.
REQ-021 Column SHALL not change in DEBOUNCE, HELD, RELEASE; additional keys pressed in other rows/columns SHALL be ignored until SCAN.
REQ-022 Emitting an event SHALL register key_code and set key_valid the following cycle; key_code stable while key_valid=1.
REQ-023 key_valid SHALL clear in the cycle after key_valid & key_ready; key_ready while key_valid=0 has no effect.
REQ-024 Event arising while key_valid=1 SHALL be dropped, pending code retained, overrun pulsed one cycle.
REQ-025 With DEBOUNCE=1, a press sampled on one tick SHALL emit on that same tick.

Reset
REQ-026 rst SHALL asynchronously force: col all-ones, key_code 0, key_valid 0, key_held 0, overrun 0, state SCAN, col_index 0, tick and debounce counters 0, synchronizer flops all-ones.
REQ-027 After rst deassert, col SHALL drive column 0 low on the first clk edge.
REQ-028 rst mid-press or mid-handshake SHALL discard pending event; a key still held after reset is re-debounced from SCAN.

Configuration
REQ-029 With KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_DLY ticks from entry or last repeat, re-emit the held key_code (subject to REQ-024); repeat counter clears on leaving HELD.
REQ-030 Without KEYPAD_REPEAT_EN: exactly one event per press; REPEAT_DLY unused; no repeat counter logic.

Verification (SCAN_DIV=4, DEBOUNCE=2, ROWS=COLS=4, REPEAT_DLY=3)
REQ-031 Reset then idle rows 4'b1111 -> col cycles 1110,1101,1011,0111,1110 every 4 clk; key_valid stays 0.
REQ-032 Row 2 low while column 1 driven, key_ready=1 -> key_code=9, one-cycle key_valid, key_held=1 until 2 release ticks.
REQ-033 Row bounce 1 tick low, 1 tick high -> no event, scanning resumes at next column.
REQ-034 key_ready=0, two presses (codes 5 then 12) -> key_code stays 5, overrun pulses once, key_valid high until ready.
REQ-035 KEYPAD_REPEAT_EN, hold code 15 for 12 ticks, key_ready=1 -> events at debounce tick then every 3 ticks; none without macro.
REQ-036 Assert rst while key_valid=1 and key held -> outputs to reset values immediately; key re-reported after 2 ticks once scan reaches its column.
